// File: rtl/pixel_tap_line.sv
// pixel_tap_line: DEPTH-tap pixel shift line with line framing and window strobe.
// Optional edge replication and end-of-line flush: PIXEL_TAP_EDGE_REPLICATE_EN.
module pixel_tap_line #(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 11
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       pix_in,
   input  logic                    pix_valid,
   input  logic                    line_start,
   input  logic                    line_end,
   output logic                    in_ready,
   output logic [DATA_W*DEPTH-1:0] taps_out,
   output logic                    taps_valid,
   output logic                    sync_err
);

   localparam int CENTER = (DEPTH - 1) / 2;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int TW     = DATA_W * DEPTH;
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
   localparam int THR    = CENTER + 1;
   localparam int FW     = $clog2(CENTER + 1);
`else
   localparam int THR    = DEPTH;
`endif

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n, cnt_inc;
   logic [TW-1:0]   taps, taps_n, shifted, started;
   logic            tv, tv_n;
   logic            se, se_n;
   logic            rdy, rdy_n;
   logic            acc;
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
   logic [FW-1:0]   fcnt, fcnt_n;
`endif

   assign in_ready   = rdy;
   assign taps_out   = taps;
   assign taps_valid = tv;
   assign sync_err   = se;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      taps_n  = taps;
      tv_n    = 1'b0;
      se_n    = 1'b0;
      rdy_n   = rdy;
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
      fcnt_n  = fcnt;
      started = {DEPTH{pix_in}};
`else
      started = {taps[TW-DATA_W-1:0], pix_in};
`endif
      acc     = pix_valid && rdy;
      cnt_inc = (cnt == CW'(DEPTH)) ? cnt : cnt + 1'b1;
      shifted = {taps[TW-DATA_W-1:0], pix_in};

      unique case (state)
         IDLE, FILL, RUN: begin
            if (acc) begin
               if (line_start) begin
                  // a start inside an open line abandons that line
                  se_n    = (state != IDLE);
                  taps_n  = started;
                  cnt_n   = CW'(1);
                  state_n = FILL;
               end else if (state == IDLE) begin
                  se_n = 1'b1;
               end else begin
                  taps_n = shifted;
                  cnt_n  = cnt_inc;
                  if (cnt_inc >= CW'(THR)) begin
                     tv_n    = 1'b1;
                     state_n = RUN;
                  end
               end
               if (line_end && (line_start || state != IDLE)) begin
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
                  state_n = FLUSH;
                  rdy_n   = 1'b0;
                  fcnt_n  = '0;
`else
                  state_n = IDLE;
`endif
               end
            end
         end
         FLUSH: begin
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
            se_n   = pix_valid;
            // tap0 already holds the last pixel, so recirculate it
            taps_n = {taps[TW-DATA_W-1:0], taps[DATA_W-1:0]};
            cnt_n  = cnt_inc;
            tv_n   = (cnt_inc >= CW'(THR));
            fcnt_n = fcnt + 1'b1;
            if (fcnt == FW'(CENTER - 1)) begin
               state_n = IDLE;
               rdy_n   = 1'b1;
            end
`else
            state_n = IDLE;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         taps  <= '0;
         tv    <= 1'b0;
         se    <= 1'b0;
         rdy   <= 1'b1;
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
         fcnt  <= '0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         taps  <= taps_n;
         tv    <= tv_n;
         se    <= se_n;
         rdy   <= rdy_n;
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
         fcnt  <= fcnt_n;
`endif
      end
   end

endmodule

// File: tb/tb_pixel_tap_line.sv
// tb_pixel_tap_line: directed vector bench for pixel_tap_line (both builds).
// Expected values are hand-derived for DATA_W=24, DEPTH=11.
module tb_pixel_tap_line;

   localparam int DW = 24;
   localparam int DP = 11;
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
   localparam bit MAC = 1'b1;
   localparam int THR = 6;
`else
   localparam bit MAC = 1'b0;
   localparam int THR = 11;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [DW-1:0]    pix_in;
   logic             pix_valid;
   logic             line_start;
   logic             line_end;
   logic             in_ready;
   logic [DW*DP-1:0] taps_out;
   logic             taps_valid;
   logic             sync_err;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   typedef struct {
      logic          v;
      logic          ls;
      logic          le;
      logic [DW-1:0] pix;
      logic          tv;
      logic          se;
      logic          rdy;
      logic [DW-1:0] t0;
      logic [DW-1:0] tl;
   } vec_t;

   vec_t vq[$];

   pixel_tap_line #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .line_start (line_start),
      .line_end   (line_end),
      .in_ready   (in_ready),
      .taps_out   (taps_out),
      .taps_valid (taps_valid),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] tapv(int k);
      return taps_out[k*DW +: DW];
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic void add(logic v, logic ls, logic le, int pix,
                               logic tv, logic se, logic rdy, int t0, int tl);
      vec_t e;
      e.v = v; e.ls = ls; e.le = le; e.pix = DW'(pix);
      e.tv = tv; e.se = se; e.rdy = rdy;
      e.t0 = DW'(t0); e.tl = DW'(tl);
      vq.push_back(e);
   endfunction

   task automatic run_vecs(string tag);
      for (int i = 0; i < vq.size(); i++) begin
         pix_valid  = vq[i].v;
         line_start = vq[i].ls;
         line_end   = vq[i].le;
         pix_in     = vq[i].pix;
         tick();
         if (taps_valid) pulses++;
         chk($sformatf("%s[%0d].tv", tag, i), 32'(taps_valid), 32'(vq[i].tv));
         chk($sformatf("%s[%0d].se", tag, i), 32'(sync_err), 32'(vq[i].se));
         chk($sformatf("%s[%0d].rdy", tag, i), 32'(in_ready), 32'(vq[i].rdy));
         chk($sformatf("%s[%0d].t0", tag, i), 32'(tapv(0)), 32'(vq[i].t0));
         chk($sformatf("%s[%0d].t10", tag, i), 32'(tapv(DP-1)), 32'(vq[i].tl));
      end
      vq.delete();
      pix_valid  = 1'b0;
      line_start = 1'b0;
      line_end   = 1'b0;
   endtask

   initial begin
      logic [DW*DP-1:0] all7;
      int tl;
      all7 = {DP{24'd7}};

      rst = 1'b1; pix_in = 24'h123; line_start = 1'b1; line_end = 1'b0;
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      tick();
      chk("rst.taps", 32'(taps_out == '0), 32'd1);
      chk("rst.tv", 32'(taps_valid), 32'd0);
      chk("rst.se", 32'(sync_err), 32'd0);
      chk("rst.rdy", 32'(in_ready), 32'd1);
      rst = 1'b0; line_start = 1'b0;

      // beat in IDLE without line_start is dropped
      pix_valid = 1'b1; pix_in = 24'h55;
      tick();
      chk("drop.se", 32'(sync_err), 32'd1);
      chk("drop.taps", 32'(taps_out == '0), 32'd1);
      chk("drop.tv", 32'(taps_valid), 32'd0);
      pix_valid = 1'b0;
      tick();
      chk("drop.se_clr", 32'(sync_err), 32'd0);

      // line 1..16 with a bubble after pixel 5
      pulses = 0;
      for (int i = 1; i <= 16; i++) begin
         if (MAC) tl = (i > 10) ? i - 10 : 1;
         else     tl = (i > 10) ? i - 10 : 0;
         add(1'b1, i == 1, i == 16, i, i >= THR, 1'b0,
             !(MAC && i == 16), i, tl);
         if (i == 5) add(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 5, MAC ? 1 : 0);
      end
      run_vecs("line");

`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (taps_valid) pulses++;
         chk($sformatf("flush%0d.tv", k), 32'(taps_valid), 32'd1);
         chk($sformatf("flush%0d.rdy", k), 32'(in_ready), 32'(k == 5));
         chk($sformatf("flush%0d.t0", k), 32'(tapv(0)), 32'd16);
         chk($sformatf("flush%0d.t10", k), 32'(tapv(10)), 32'(6 + k));
      end
      chk("flush.t5", 32'(tapv(5)), 32'd16);
      chk("line.pulses", 32'(pulses), 32'd16);
      tick();
      chk("flush.idle_tv", 32'(taps_valid), 32'd0);
`else
      chk("line.pulses", 32'(pulses), 32'd6);
      pix_valid = 1'b1; pix_in = 24'h99;
      tick();
      chk("eol.se", 32'(sync_err), 32'd1);
      chk("eol.t0", 32'(tapv(0)), 32'd16);
      pix_valid = 1'b0;
`endif

      // line_start at pixel 4 restarts the line
      add(1'b1, 1'b1, 1'b0, 100, 1'b0, 1'b0, 1'b1, 100, MAC ? 100 : 7);
      add(1'b1, 1'b0, 1'b0, 101, 1'b0, 1'b0, 1'b1, 101, MAC ? 100 : 8);
      add(1'b1, 1'b0, 1'b0, 102, 1'b0, 1'b0, 1'b1, 102, MAC ? 100 : 9);
      add(1'b1, 1'b1, 1'b0, 200, 1'b0, 1'b1, 1'b1, 200, MAC ? 200 : 10);
      for (int v = 201; v <= 210; v++) begin
         if (MAC)         tl = 200;
         else if (v <= 206) tl = v - 190;
         else if (v <= 209) tl = v - 107;
         else             tl = 200;
         add(1'b1, 1'b0, 1'b0, v, (v - 199) >= THR, 1'b0, 1'b1, v, tl);
      end
      run_vecs("restart");

      // reset in an open line
      rst = 1'b1; pix_valid = 1'b1; pix_in = 24'h77;
      tick();
      chk("rstmid.taps", 32'(taps_out == '0), 32'd1);
      chk("rstmid.rdy", 32'(in_ready), 32'd1);
      chk("rstmid.tv", 32'(taps_valid), 32'd0);
      chk("rstmid.se", 32'(sync_err), 32'd0);
      rst = 1'b0; pix_in = 24'h78;
      tick();
      chk("rstmid.idle_se", 32'(sync_err), 32'd1);
      chk("rstmid.idle_taps", 32'(taps_out == '0), 32'd1);
      pix_valid = 1'b0;

      // one-pixel line
      pix_valid = 1'b1; line_start = 1'b1; line_end = 1'b1; pix_in = 24'd7;
      tick();
      pix_valid = 1'b0; line_start = 1'b0; line_end = 1'b0;
      chk("one.tv", 32'(taps_valid), 32'd0);
      chk("one.t0", 32'(tapv(0)), 32'd7);
`ifdef PIXEL_TAP_EDGE_REPLICATE_EN
      chk("one.all7", 32'(taps_out == all7), 32'd1);
      chk("one.rdy", 32'(in_ready), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         pix_valid = (k == 2);
         pix_in = 24'hEE;
         tick();
         chk($sformatf("oneflush%0d.tv", k), 32'(taps_valid), 32'(k == 5));
         chk($sformatf("oneflush%0d.se", k), 32'(sync_err), 32'(k == 2));
         chk($sformatf("oneflush%0d.rdy", k), 32'(in_ready), 32'(k == 5));
      end
      pix_valid = 1'b0;
      chk("oneflush.all7", 32'(taps_out == all7), 32'd1);

      // reset on the 2nd flush cycle
      add(1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1, 1);
      add(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 2, 1);
      add(1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 3, 1);
      add(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3, 1);
      run_vecs("rstfl");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstfl.taps", 32'(taps_out == '0), 32'd1);
      chk("rstfl.rdy", 32'(in_ready), 32'd1);
      chk("rstfl.tv", 32'(taps_valid), 32'd0);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (taps_valid) pulses++;
      end
      chk("rstfl.pulses", 32'(pulses), 32'd0);
      chk("rstfl.rdy_hold", 32'(in_ready), 32'd1);
`else
      chk("one.t1", 32'(tapv(1)), 32'd0);
      chk("one.rdy", 32'(in_ready), 32'd1);
      pix_valid = 1'b1; pix_in = 24'd8;
      tick();
      pix_valid = 1'b0;
      chk("one.idle_se", 32'(sync_err), 32'd1);
      chk("one.idle_t0", 32'(tapv(0)), 32'd7);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_tap_line.md
# pixel_tap_line

Parametrised pixel tap line for the D8M video pipeline: a `DEPTH`-tap, `DATA_W`-bit shift register with per-line framing, fill tracking and a window-valid strobe. It sits between the camera pixel stream and the 1-D horizontal filter kernels, which consume all taps in parallel. It extends the fixed 11×24-bit shift chain with line-boundary awareness, optional edge replication with end-of-line flush, and backpressure during flush.

## Interface
- `DATA_W`, 24: pixel width in bits.
- `DEPTH`, 11: number of taps; must be odd and ≥ 3. `CENTER = (DEPTH-1)/2`, derived, not overridable.
- `clk` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `pix_in` in `DATA_W`: input pixel.
- `pix_valid` in 1: `pix_in` is valid this cycle.
- `line_start` in 1: qualifies the first pixel of a line; meaningful only with `pix_valid`.
- `line_end` in 1: qualifies the last pixel of a line; meaningful only with `pix_valid`.
- `in_ready` out 1: block accepts pixels; registered.
- `taps_out` out `DATA_W*DEPTH`: tap k at bits `[k*DATA_W +: DATA_W]`; tap 0 is the newest pixel.
- `taps_valid` out 1: one-cycle strobe; `taps_out` holds a valid window this cycle.
- `sync_err` out 1: one-cycle strobe; a framing violation was dropped.

## Operation
- A beat is accepted when `pix_valid && in_ready`. Only accepted beats, plus flush cycles, shift the taps.
- Shift: tap0 ← `pix_in`, tap k ← tap k-1.
- The fill counter `cnt` has width `$clog2(DEPTH+1)` and saturates at `DEPTH`.
- The FSM has four states: IDLE, FILL, RUN, FLUSH.
- **IDLE:**
  - An accepted beat with `line_start` shifts, sets `cnt=1` and moves to FILL.
  - An accepted beat without `line_start` is dropped: the taps are unchanged and `sync_err` pulses.
- **FILL/RUN:**
  - Every accepted beat shifts and increments `cnt`.
  - The state moves from FILL to RUN when `cnt` reaches `THR`, where `THR = DEPTH` without the macro and `CENTER+1` with it.
  - `taps_valid` pulses for every shift that leaves `cnt ≥ THR`.
- **line_end:**
  - Without the macro, the beat is processed, then the state returns to IDLE.
  - With the macro, the state goes to FLUSH.
- **line_start while in FILL/RUN** (missing `line_end`): the current line is abandoned, `sync_err` pulses, and the beat is treated as a new line start (`cnt=1`, state FILL).
- **line_start and line_end on the same beat:** start handling is applied first, then end handling.
- **FLUSH** (macro only):
  - Runs for exactly `CENTER` cycles. Each cycle shifts in a copy of the last accepted pixel, increments `cnt` and pulses `taps_valid` if `cnt ≥ THR`.
  - Then returns to IDLE.
  - `in_ready` is 0 throughout FLUSH. `pix_valid` during FLUSH is ignored and pulses `sync_err`.
- **Valid windows per line of W pixels:** `max(W-DEPTH+1, 0)` without the macro; exactly W with it (the center tap steps through pixels 1..W).

## Timing
- **Reset values:**
  - All taps 0, `taps_valid` 0, `sync_err` 0, `in_ready` 1.
  - State IDLE, `cnt` 0.
- `rst` overrides everything, including in mid-FILL or mid-FLUSH. The block is in IDLE the cycle after `rst` is sampled high.
- **Latency:** a beat accepted at edge t appears on tap0 after edge t. `taps_valid` and `sync_err` are registered on the same edge, so they align with the updated `taps_out`.
- **Flush timing:** `line_end` accepted at edge t gives `in_ready`=0 after edge t, flush shifts at edges t+1 … t+CENTER, and `in_ready`=1 after edge t+CENTER.
- There is no combinational path from inputs to outputs.

## Configuration
- `PIXEL_TAP_EDGE_REPLICATE_EN`, when defined:
  - `line_start` preloads all `DEPTH` taps with `pix_in` instead of a single shift.
  - `THR = CENTER+1`.
  - `line_end` triggers a `CENTER`-cycle FLUSH that replicates the last pixel, with `in_ready` deasserted.
- When undefined:
  - The plain shift applies on `line_start` and `THR = DEPTH`.
  - There is no FLUSH state; `in_ready` is tied to 1 after reset.

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with `pix_valid` toggling → all taps 0, `taps_valid`=0, `sync_err`=0, `in_ready`=1.
- **No macro, line 1..16 (DEPTH=11):** first `taps_valid` after pixel 11 with tap0=11 … tap10=1; exactly 6 pulses; last window tap0=16, tap10=6.
- **Macro, line 1..16:**
  - After pixel 1, all taps =1 and no strobe.
  - First `taps_valid` after pixel 6 (tap5=1).
  - `in_ready`=0 for 5 cycles after `line_end`.
  - 16 pulses total; the final window has tap0..tap5=16 and tap10=11.
- **Macro, 1-pixel line** (`line_start` and `line_end` on value 7): all taps 7, 5 flush cycles, exactly one `taps_valid` on the 5th flush cycle.
- **Framing errors:**
  - `pix_valid` in IDLE without `line_start` → `sync_err` pulse, taps unchanged.
  - `line_start` at pixel 4 of a line → `sync_err` pulse, `cnt` restarts at 1, no `taps_valid` until `THR` new pixels have been accepted.
- **Macro, `rst` asserted on the 2nd flush cycle:** IDLE next cycle, `in_ready`=1, taps 0, no further `taps_valid`.
